// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Contents:
//   REG_AW_DEF    register address width used to size tracker entries
//   trk_entry_t   one shadow-pipe entry {valid, rd, reg_write, is_load}
//   flush_state_t flush FSM states
//   FWD_*         forward-select encodings (0 = regfile, k = tracked stage k-1)
package hazard_pkg;

  // Tracker entries are sized by this width; REG_AW of the users must not exceed it.
  localparam int unsigned REG_AW_DEF = 5;

  typedef struct packed {
    logic                  valid;
    logic [REG_AW_DEF-1:0] rd;
    logic                  reg_write;
    logic                  is_load;
  } trk_entry_t;

  typedef enum logic {
    ST_RUN,
    ST_FLUSH
  } flush_state_t;

  localparam int unsigned FWD_NONE = 0;
  localparam int unsigned FWD_EX   = 1;
  localparam int unsigned FWD_MEM  = 2;
  localparam int unsigned FWD_WB   = 3;

endpackage

// File: rtl/hazard_src_match.sv
// Per-operand hazard check against the destination-register tracker.
// Finds the youngest tracked stage writing the operand's register; requests a
// stall if that producer is a load not yet forwardable, otherwise returns the
// forward select (stage index + 1, or 0 when nothing matches).
// Ports:
//   id_valid   in   ID holds a real instruction
//   src_addr   in   operand register address
//   src_used   in   operand is actually read
//   trk        in   tracker entries, index 0 = EX
//   stall_req  out  operand needs a load-use stall
//   fwd_sel    out  forward select for this operand
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned FWD_STAGES = 3,
  parameter int          LOAD_LAT   = 1,
  parameter int unsigned SEL_W      = $clog2(FWD_STAGES + 1)
) (
  input  logic                              id_valid,
  input  logic [REG_AW-1:0]                 src_addr,
  input  logic                              src_used,
  input  trk_entry_t [FWD_STAGES-1:0]       trk,
  output logic                              stall_req,
  output logic [SEL_W-1:0]                  fwd_sel
);

  logic found;

  always_comb begin
    stall_req = 1'b0;
    fwd_sel   = SEL_W'(FWD_NONE);
    found     = 1'b0;
    // Ascending scan; the first hit is the youngest producer and wins.
    for (int s = 0; s < int'(FWD_STAGES); s++) begin
      if (!found && id_valid && src_used && trk[s].valid && trk[s].reg_write &&
          trk[s].rd == REG_AW_DEF'(src_addr)) begin
        found = 1'b1;
        if (trk[s].is_load && s < LOAD_LAT) begin
          stall_req = 1'b1;
        end else begin
          fwd_sel = SEL_W'(s + 1);
        end
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline. Tracks in-flight destination
// registers for the stages after ID, produces load-use stalls, per-operand
// forward selects and a multi-cycle flush on taken branches.
// Optional feature: define HAZ_PERF_CNT_EN to add saturating stall/flush
// cycle counters.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   id_valid       ID holds a real instruction
//   id_src_addr    operand i at [i*REG_AW +: REG_AW]
//   id_src_used    per-operand read flags
//   id_rd          ID destination register
//   id_reg_write   ID instruction writes the register file
//   id_is_load     ID instruction is a load
//   ex_br_taken    taken branch resolved in EX
//   stall          hold PC and IF/ID
//   ex_bubble      load a bubble into ID/EX
//   flush          squash IF/ID
//   fwd_sel        operand i at [i*SEL_W +: SEL_W]; 0 = regfile, k = stage k-1
//   stall_cycles   (HAZ_PERF_CNT_EN) cycles with stall=1
//   flush_cycles   (HAZ_PERF_CNT_EN) cycles with flush=1
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned NUM_SRC     = 2,
  parameter int unsigned FWD_STAGES  = 3,
  parameter int          LOAD_LAT    = 1,
  parameter int unsigned FLUSH_DEPTH = 2,
  parameter int unsigned SEL_W       = $clog2(FWD_STAGES + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]   id_src_addr,
  input  logic [NUM_SRC-1:0]          id_src_used,
  input  logic [REG_AW-1:0]           id_rd,
  input  logic                        id_reg_write,
  input  logic                        id_is_load,
  input  logic                        ex_br_taken,
  output logic                        stall,
  output logic                        ex_bubble,
  output logic                        flush,
  output logic [NUM_SRC*SEL_W-1:0]    fwd_sel
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]                 stall_cycles,
  output logic [31:0]                 flush_cycles
`endif
);

  localparam int unsigned CNT_W = $clog2(FLUSH_DEPTH + 1);

  trk_entry_t [FWD_STAGES-1:0] trk_q, trk_d;
  flush_state_t                state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        flush_raw;
  logic [NUM_SRC-1:0]          stall_req;
  logic [NUM_SRC*SEL_W-1:0]    fwd_raw;

  // Per-operand match logic
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    hazard_src_match #(
      .REG_AW    (REG_AW),
      .FWD_STAGES(FWD_STAGES),
      .LOAD_LAT  (LOAD_LAT),
      .SEL_W     (SEL_W)
    ) u_match (
      .id_valid (id_valid),
      .src_addr (id_src_addr[i*REG_AW +: REG_AW]),
      .src_used (id_src_used[i]),
      .trk      (trk_q),
      .stall_req(stall_req[i]),
      .fwd_sel  (fwd_raw[i*SEL_W +: SEL_W])
    );
  end

  // Outputs are forced quiet during reset, independent of stale state.
  assign flush     = flush_raw & ~rst;
  assign stall     = (|stall_req) & ~flush_raw & ~rst;
  assign ex_bubble = stall | flush;
  assign fwd_sel   = rst ? '0 : fwd_raw;

  // Shadow pipe: shift towards WB, inject a bubble on stall or flush.
  always_comb begin
    trk_d = trk_q;
    for (int s = int'(FWD_STAGES) - 1; s > 0; s--) begin
      trk_d[s] = trk_q[s-1];
    end
    if (ex_bubble) begin
      trk_d[0] = '0;
    end else begin
      trk_d[0].valid     = id_valid;
      trk_d[0].rd        = REG_AW_DEF'(id_rd);
      trk_d[0].reg_write = id_reg_write;
      trk_d[0].is_load   = id_is_load;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trk_q <= '0;
    end else begin
      trk_q <= trk_d;
    end
  end

  // Flush FSM: first flush cycle comes straight from ex_br_taken in RUN; the
  // remaining FLUSH_DEPTH-1 cycles are counted down in FLUSH.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    flush_raw = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (ex_br_taken) begin
          flush_raw = 1'b1;
          if (FLUSH_DEPTH > 1) begin
            state_d = ST_FLUSH;
            cnt_d   = CNT_W'(FLUSH_DEPTH - 1);
          end
        end
      end
      ST_FLUSH: begin
        // Branches seen here come from the squashed path.
        flush_raw = 1'b1;
        cnt_d     = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && stall_cnt_q != 32'hFFFF_FFFF) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (flush && flush_cnt_q != 32'hFFFF_FFFF) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_cycles = flush_cnt_q;
`endif

endmodule
